fp_sqrt: RTL and testbench



---
 rtl/sqrt_pkg.sv | 29 ++
 rtl/sqrt_step.sv | 30 +++
 rtl/fp_sqrt.sv | 121 ++++++++++++
 tb/tb_fp_sqrt.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/sqrt_pkg.sv
// Shared types and parameter helpers for the fixed-point square root.
// Holds the controller state encoding plus the iteration and cycle-count arithmetic.
package sqrt_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } sqrt_state_t;

  function automatic int calcIters(input int width, input int fracWidth);
    return (width + fracWidth) / 2;
  endfunction

  function automatic int calcNumCycles(input int width, input int fracWidth, input int steps);
    return calcIters(width, fracWidth) / steps;
  endfunction

  function automatic bit widthsLegal(input int width, input int fracWidth);
    return (width > 0) && (fracWidth >= 0) && (fracWidth <= width)
           && (((width + fracWidth) % 2) == 0);
  endfunction

  function automatic bit stepsLegal(input int width, input int fracWidth, input int steps);
    return ((steps == 1) || (steps == 2) || (steps == 4))
           && ((calcIters(width, fracWidth) % steps) == 0);
  endfunction

endpackage

// File: rtl/sqrt_step.sv
// One restoring digit iteration: bring down two radicand bits and try to subtract {q, 01}.
module sqrt_step #(
  parameter int WIDTH = 32,
  parameter int ITERS = 24
) (
  input  logic [WIDTH+1:0] i_acc,
  input  logic [ITERS-1:0] i_q,
  input  logic [1:0]       i_digits,
  output logic [WIDTH+1:0] o_acc,
  output logic [ITERS-1:0] o_q
);

  localparam int TW = WIDTH + 3;

  logic [TW-1:0] w_accShift;
  logic [TW-1:0] w_trial;
  logic [TW-1:0] w_diff;
  logic          w_neg;

  // The running remainder never exceeds 2q, so its top bit is always zero and
  // dropping it keeps the sign of the trial subtraction in bit TW-1.
  assign w_accShift = TW'({i_acc, i_digits});
  assign w_trial    = TW'({i_q, 2'b01});
  assign w_diff     = w_accShift - w_trial;
  assign w_neg      = w_diff[TW-1];

  assign o_acc = w_neg ? w_accShift[WIDTH+1:0] : w_diff[WIDTH+1:0];
  assign o_q   = ITERS'({i_q, ~w_neg});

endmodule

// File: rtl/fp_sqrt.sv
// Multi-cycle fixed-point square root with exact remainder behind a go/done handshake.
// Retires STEPS_PER_CYCLE digit iterations per RUN cycle through a chain of sqrt_step.
module fp_sqrt
  import sqrt_pkg::*;
#(
  parameter int WIDTH           = 32,
  parameter int FRAC_WIDTH      = 16,
  parameter int STEPS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             go,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH:0]   rem,
  output logic             done
);

  localparam int ITERS = calcIters(WIDTH, FRAC_WIDTH);
  localparam int RAD_W = WIDTH + FRAC_WIDTH;
  localparam int ACC_W = WIDTH + 2;
  localparam int N     = calcNumCycles(WIDTH, FRAC_WIDTH, STEPS_PER_CYCLE);
  localparam int CNT_W = $clog2(N + 1);

  if (!widthsLegal(WIDTH, FRAC_WIDTH)) begin : g_badWidths
    $error("fp_sqrt: FRAC_WIDTH must be 0..WIDTH and WIDTH+FRAC_WIDTH must be even");
  end
  if (!stepsLegal(WIDTH, FRAC_WIDTH, STEPS_PER_CYCLE)) begin : g_badSteps
    $error("fp_sqrt: STEPS_PER_CYCLE must be 1, 2 or 4 and divide (WIDTH+FRAC_WIDTH)/2");
  end

  sqrt_state_t r_state;
  sqrt_state_t w_nextState;

  logic [RAD_W-1:0] r_rad;
  logic [ACC_W-1:0] r_acc;
  logic [ITERS-1:0] r_q;
  logic [CNT_W-1:0] r_count;
  logic [WIDTH-1:0] r_out;
  logic [WIDTH:0]   r_rem;
  logic             w_lastRun;

  logic [STEPS_PER_CYCLE:0][ACC_W-1:0] w_accChain;
  logic [STEPS_PER_CYCLE:0][ITERS-1:0] w_qChain;

  assign w_accChain[0] = r_acc;
  assign w_qChain[0]   = r_q;

  for (genvar s = 0; s < STEPS_PER_CYCLE; s++) begin : g_step
    sqrt_step #(
      .WIDTH(WIDTH),
      .ITERS(ITERS)
    ) u_step (
      .i_acc   (w_accChain[s]),
      .i_q     (w_qChain[s]),
      .i_digits(r_rad[RAD_W-1-2*s -: 2]),
      .o_acc   (w_accChain[s+1]),
      .o_q     (w_qChain[s+1])
    );
  end

  assign w_lastRun = (r_state == RUN) && (r_count == CNT_W'(N - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (go) w_nextState = RUN;
      RUN:     if (w_lastRun) w_nextState = DONE;
      DONE:    w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Results are only written on the final RUN cycle, so out/rem stay stable
  // across a following computation until its own DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rad   <= '0;
      r_acc   <= '0;
      r_q     <= '0;
      r_count <= '0;
      r_out   <= '0;
      r_rem   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (go) begin
            r_rad   <= RAD_W'(in) << FRAC_WIDTH;
            r_acc   <= '0;
            r_q     <= '0;
            r_count <= '0;
          end
        end
        RUN: begin
          r_rad   <= r_rad << (2 * STEPS_PER_CYCLE);
          r_acc   <= w_accChain[STEPS_PER_CYCLE];
          r_q     <= w_qChain[STEPS_PER_CYCLE];
          r_count <= r_count + CNT_W'(1);
          if (w_lastRun) begin
            r_out <= WIDTH'(w_qChain[STEPS_PER_CYCLE]);
            r_rem <= w_accChain[STEPS_PER_CYCLE][WIDTH:0];
          end
        end
        default: ;
      endcase
    end
  end

  assign out  = r_out;
  assign rem  = r_rem;
  assign done = (r_state == DONE);

endmodule

// File: tb/tb_fp_sqrt.sv
// Self-checking bench: three fp_sqrt configurations share one stimulus stream and are
// compared every cycle against an arithmetic floor-sqrt model with go/done timing.
module tb_fp_sqrt;

  localparam int NDUT = 3;
  localparam int N_CYC [NDUT] = '{24, 6, 8};
  localparam int FRAC  [NDUT] = '{16, 16, 0};
  localparam int LAT   [NDUT] = '{25, 7, 9};

  logic        clk   = 1'b0;
  logic        reset = 1'b1;
  logic        go    = 1'b0;
  logic [31:0] inVal = '0;

  logic [31:0] dOut  [NDUT];
  logic [32:0] dRem  [NDUT];
  logic        dDone [NDUT];

  string nm [NDUT] = '{"A", "B", "C"};
  int nVec = 0;
  int nMis = 0;

  always #5 clk = ~clk;

  fp_sqrt #(.WIDTH(32), .FRAC_WIDTH(16), .STEPS_PER_CYCLE(1)) dutA (
    .clk(clk), .reset(reset), .go(go), .in(inVal),
    .out(dOut[0]), .rem(dRem[0]), .done(dDone[0])
  );
  fp_sqrt #(.WIDTH(32), .FRAC_WIDTH(16), .STEPS_PER_CYCLE(4)) dutB (
    .clk(clk), .reset(reset), .go(go), .in(inVal),
    .out(dOut[1]), .rem(dRem[1]), .done(dDone[1])
  );
  fp_sqrt #(.WIDTH(32), .FRAC_WIDTH(0), .STEPS_PER_CYCLE(2)) dutC (
    .clk(clk), .reset(reset), .go(go), .in(inVal),
    .out(dOut[2]), .rem(dRem[2]), .done(dDone[2])
  );

  function automatic logic [63:0] isqrt(input logic [63:0] r);
    logic [63:0] lo;
    logic [63:0] hi;
    logic [63:0] mid;
    lo = 64'd0;
    hi = 64'd1 << 25;
    while (hi - lo > 64'd1) begin
      mid = (lo + hi) >> 1;
      if (mid * mid <= r) lo = mid;
      else hi = mid;
    end
    return lo;
  endfunction

  // Reference model: result from plain arithmetic, timing as a countdown from accept.
  int          left    [NDUT];
  logic [31:0] pendOut [NDUT];
  logic [32:0] pendRem [NDUT];
  logic [31:0] expOut  [NDUT];
  logic [32:0] expRem  [NDUT];
  logic        expDone [NDUT];
  logic [63:0] mR;
  logic [63:0] mS;

  always @(posedge clk) begin
    for (int d = 0; d < NDUT; d++) begin
      if (reset) begin
        left[d]    = 0;
        expDone[d] = 1'b0;
        expOut[d]  = '0;
        expRem[d]  = '0;
      end else if (left[d] == 0) begin
        expDone[d] = 1'b0;
        if (go) begin
          mR         = {32'd0, inVal} << FRAC[d];
          mS         = isqrt(mR);
          pendOut[d] = mS[31:0];
          pendRem[d] = 33'(mR - mS * mS);
          left[d]    = N_CYC[d] + 1;
        end
      end else begin
        left[d]    = left[d] - 1;
        expDone[d] = (left[d] == 1);
        if (left[d] == 1) begin
          expOut[d] = pendOut[d];
          expRem[d] = pendRem[d];
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    nVec++;
    if (act !== exp) begin
      nMis++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    for (int d = 0; d < NDUT; d++) begin
      checkOutput({nm[d], ".done"}, 64'(dDone[d]), 64'(expDone[d]));
      checkOutput({nm[d], ".out"},  64'(dOut[d]),  64'(expOut[d]));
      checkOutput({nm[d], ".rem"},  64'(dRem[d]),  64'(expRem[d]));
    end
  endtask

  task automatic applyStimulus(input logic [31:0] v,
                               input logic [31:0] eOutA, input logic [32:0] eRemA,
                               input logic [31:0] eOutC, input logic [32:0] eRemC);
    int          first [NDUT];
    logic [31:0] gotOut [NDUT];
    logic [32:0] gotRem [NDUT];
    for (int d = 0; d < NDUT; d++) begin
      first[d]  = -1;
      gotOut[d] = '0;
      gotRem[d] = '0;
    end
    inVal = v;
    go    = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (k == 1) begin
        go    = 1'b0;
        inVal = ~v;
      end
      for (int d = 0; d < NDUT; d++) begin
        if (dDone[d] === 1'b1 && first[d] < 0) begin
          first[d]  = k;
          gotOut[d] = dOut[d];
          gotRem[d] = dRem[d];
        end
      end
    end
    for (int d = 0; d < NDUT; d++) begin
      checkOutput($sformatf("%s.latency(in=%h)", nm[d], v), 64'(first[d]), 64'(LAT[d]));
    end
    checkOutput($sformatf("A.out(in=%h)", v), 64'(gotOut[0]), 64'(eOutA));
    checkOutput($sformatf("A.rem(in=%h)", v), 64'(gotRem[0]), 64'(eRemA));
    checkOutput($sformatf("B.out(in=%h)", v), 64'(gotOut[1]), 64'(eOutA));
    checkOutput($sformatf("B.rem(in=%h)", v), 64'(gotRem[1]), 64'(eRemA));
    checkOutput($sformatf("C.out(in=%h)", v), 64'(gotOut[2]), 64'(eOutC));
    checkOutput($sformatf("C.rem(in=%h)", v), 64'(gotRem[2]), 64'(eRemC));
  endtask

  logic [31:0] edgeVals [4] = '{32'h0, 32'hFFFF_FFFF, 32'h1, 32'h8000_0000};

  initial begin
    int pos[$];
    int aborted;

    checkOutput("model.sqrt4",   isqrt(64'h4_0000 << 16), 64'h2_0000);
    checkOutput("model.sqrt2",   isqrt(64'h2_0000 << 16), 64'h1_6A09);
    checkOutput("model.rem2",    (64'h2_0000 << 16) - isqrt(64'h2_0000 << 16) ** 2, 64'h2_8BAF);
    checkOutput("model.sqrtMax", isqrt(64'hFFFF_FFFF), 64'hFFFF);

    reset = 1'b1;
    go    = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    tick();

    applyStimulus(32'h0004_0000, 32'h0002_0000, 33'h0,         32'h200,  33'h0);
    applyStimulus(32'h0002_0000, 32'h0001_6A09, 33'h2_8BAF,    32'h16A,  33'h1C);
    applyStimulus(32'hFFFF_FFFF, 32'h00FF_FFFF, 33'h1FE_FFFF,  32'hFFFF, 33'h1_FFFE);
    applyStimulus(32'h0000_0000, 32'h0,         33'h0,         32'h0,    33'h0);

    // go held high: three back-to-back results on A, input changing every cycle
    inVal = 32'h0001_0000;
    go    = 1'b1;
    for (int k = 1; k <= 77; k++) begin
      tick();
      if (dDone[0] === 1'b1) pos.push_back(k);
      inVal = 32'h0001_0000 + 32'(k) * 32'h0013_57AB;
      if (k == 77) go = 1'b0;
    end
    checkOutput("A.pulseCount", 64'(pos.size()), 64'd3);
    checkOutput("A.firstPulse", 64'((pos.size() > 0) ? pos[0] : -1), 64'd25);
    for (int i = 1; i < 3; i++) begin
      checkOutput("A.pulseSpacing", 64'((pos.size() > i) ? pos[i] - pos[i-1] : -1), 64'd26);
    end
    repeat (30) tick();

    // reset five cycles into RUN aborts every instance
    inVal = 32'h0009_0000;
    go    = 1'b1;
    tick();
    go = 1'b0;
    repeat (4) tick();
    reset = 1'b1;
    tick();
    reset   = 1'b0;
    aborted = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      for (int d = 0; d < NDUT; d++) if (dDone[d] === 1'b1) aborted++;
    end
    checkOutput("abort.donePulses", 64'(aborted), 64'd0);
    checkOutput("abort.A.out", 64'(dOut[0]), 64'd0);
    checkOutput("abort.A.rem", 64'(dRem[0]), 64'd0);
    applyStimulus(32'h0002_0000, 32'h0001_6A09, 33'h2_8BAF, 32'h16A, 33'h1C);

    go = 1'b1;
    for (int k = 0; k < 1500; k++) begin
      inVal = ((k % 7) == 0) ? edgeVals[(k / 7) % 4] : $urandom();
      tick();
    end
    go = 1'b0;
    repeat (30) tick();

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule
